amo_sequencer: RTL and testbench
================================

# amo_sequencer

Read-modify-write sequencer for RV64A AMO instructions, placed between the load/store issue path and the `amo_unit` ALU. It accepts one AMO request and performs these steps in order:

- reads the doubleword from memory;
- feeds the old value and rs2 to `amo_unit`;
- writes the ALU result back to memory;
- returns the old value for rd.

Only one operation is in flight at a time. Memory access is non-speculative once the write phase starts.

## Interface
- Parameters: none. Data width is fixed at 64, funct width at 3.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  AMO request valid
- req_ready_o  out  1  sequencer can accept a request
- req_addr_i  in  64  byte address
- req_data_i  in  64  rs2 operand
- req_funct_i  in  3  AMO function (0 = add, 1 = swap), passed through to the ALU
- req_rd_i  in  5  destination register tag
- flush_i  in  1  pipeline flush
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  64  memory address
- mem_wdata_o  out  64  write data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid, or write acknowledge
- mem_rdata_i  in  64  read data
- mem_err_i  in  1  access fault, qualified by mem_rvalid_i
- alu_valid_o  out  1  one-cycle start pulse to `amo_unit`
- alu_op_a_o  out  64  old memory value
- alu_op_b_o  out  64  rs2
- alu_funct_o  out  3  function code
- alu_ready_i  in  1  `amo_unit` result valid
- alu_result_i  in  64  `amo_unit` result
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- resp_data_o  out  64  old memory value
- resp_rd_o  out  5  destination tag
- resp_err_o  out  1  fault (misaligned or memory error)

## Operation
- States: IDLE, RD_REQ, RD_WAIT, EXEC, EXEC_WAIT, WR_REQ, WR_WAIT, DRAIN, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i: latch addr, data, funct and rd.
  - If addr[2:0] != 0: set err and go to RESP; no memory access occurs.
  - Otherwise go to RD_REQ.
- RD_REQ:
  - Drive mem_req_o = 1, mem_we_o = 0, mem_addr_o = latched addr.
  - Hold these until mem_gnt_i, then go to RD_WAIT.
- RD_WAIT:
  - On mem_rvalid_i, latch mem_rdata_i as old value.
  - If mem_err_i = 1: set err and go to RESP.
  - Otherwise go to EXEC.
- EXEC:
  - alu_valid_o = 1 for exactly one cycle, then go to EXEC_WAIT.
- EXEC_WAIT:
  - On alu_ready_i, latch alu_result_i and go to WR_REQ.
- WR_REQ:
  - Drive mem_req_o = 1, mem_we_o = 1, mem_wdata_o = latched result, held until mem_gnt_i.
  - Then go to WR_WAIT.
- WR_WAIT:
  - On mem_rvalid_i: err = mem_err_i, then go to RESP.
- RESP:
  - resp_valid_o = 1; resp_data_o = old value (0 if no read completed); resp_rd_o = latched rd; resp_err_o = err.
  - Outputs stay stable until resp_ready_i, then go to IDLE.
- alu_op_a_o, alu_op_b_o and alu_funct_o are driven from latched registers and are stable from EXEC through EXEC_WAIT.
- Flush handling:
  - IDLE: flush has no effect; a request offered with flush_i is not accepted.
  - RD_REQ without gnt: drop the request and go to IDLE.
  - RD_REQ with gnt in the same cycle: go to DRAIN.
  - RD_WAIT: go to DRAIN, unless mem_rvalid_i is also high that cycle, in which case go to IDLE.
  - DRAIN: wait for mem_rvalid_i, discard the data, go to IDLE.
  - EXEC or EXEC_WAIT: go to IDLE; a late alu_ready_i is ignored.
  - WR_REQ, WR_WAIT and RESP: flush is ignored and the operation completes with a response.
- No response is produced for a flushed operation. No write is issued after a flush taken before WR_REQ.
- mem_req_o is never deasserted before mem_gnt_i, except for a flush in RD_REQ.

## Timing
- Reset values:
  - State = IDLE.
  - All outputs 0, including req_ready_o.
  - req_ready_o goes to 1 on the first clock edge after rst_n deasserts.
- Asserting reset mid-operation aborts immediately. The memory side must be reset together with the sequencer.
- Best-case latency, with gnt in the request cycle and rvalid one cycle after gnt (C0 = accept):
  - RD_REQ C1
  - RD_WAIT C2
  - EXEC C3
  - EXEC_WAIT C4
  - WR_REQ C5
  - WR_WAIT C6
  - resp_valid_o C7
- Misaligned request: resp_valid_o in C1.
- Read error: resp_valid_o 1 cycle after the erroring rvalid.
- req_ready_o is low from the cycle after accept until the cycle after the response handshake.
- Back-to-back throughput: at most one operation per 8 cycles.

## Test plan
- AMOADD: mem[0x1000] = 5, rs2 = 3, funct = 0, rd = 7 -> read 0x1000, write 8 to 0x1000, resp_data = 5, rd = 7, err = 0, resp_valid_o in C7.
- AMOSWAP: mem[0x2008] = 0xAAAA, rs2 = 0x5555, funct = 1 -> write 0x5555, resp_data = 0xAAAA; mem_gnt_i delayed 3 cycles on both phases -> addr and wdata held stable, response delayed by 6 cycles.
- Misaligned addr 0x1004 -> mem_req_o never asserted, resp_err = 1, resp_data = 0, resp_valid_o in C1.
- Read fault: mem_err_i with read rvalid -> no write issued, resp_err = 1; write-ack fault -> resp_err = 1, resp_data = old value.
- Flush in RD_WAIT -> DRAIN absorbs the later rvalid, no write, no response, req_ready_o = 1 the cycle after drain; flush in WR_WAIT -> ignored, full response produced.
- resp_ready_i held low 4 cycles -> resp_* stable, req_ready_o = 0, a new req_valid_i is not accepted.

Source files
------------

// File: rtl/amo_sequencer.sv
// rtl/amo_sequencer.sv - RV64A AMO read-modify-write sequencer
// Reads a doubleword, runs it through amo_unit, writes the result back and returns the old value.
module amo_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_data_i,
  input  logic [2:0]  req_funct_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        alu_valid_o,
  output logic [63:0] alu_op_a_o,
  output logic [63:0] alu_op_b_o,
  output logic [2:0]  alu_funct_o,
  input  logic        alu_ready_i,
  input  logic [63:0] alu_result_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_err_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_EXEC,
    S_EXEC_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        ready_q;
  logic [63:0] addr_q, data_q, old_q, result_q;
  logic [2:0]  funct_q;
  logic [4:0]  rd_q;
  logic        err_q;
  logic        accept;
  logic        misaligned;

  // ready_q keeps req_ready_o low until the first edge after reset release
  assign accept     = ready_q && (state_q == S_IDLE) && req_valid_i && !flush_i;
  assign misaligned = (req_addr_i[2:0] != 3'b000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      addr_q   <= 64'd0;
      data_q   <= 64'd0;
      old_q    <= 64'd0;
      result_q <= 64'd0;
      funct_q  <= 3'd0;
      rd_q     <= 5'd0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (accept) begin
        addr_q  <= req_addr_i;
        data_q  <= req_data_i;
        funct_q <= req_funct_i;
        rd_q    <= req_rd_i;
        old_q   <= 64'd0;
        err_q   <= misaligned;
      end
      if ((state_q == S_RD_WAIT) && mem_rvalid_i && !flush_i) begin
        old_q <= mem_rdata_i;
        err_q <= mem_err_i;
      end
      if ((state_q == S_EXEC_WAIT) && alu_ready_i && !flush_i) begin
        result_q <= alu_result_i;
      end
      if ((state_q == S_WR_WAIT) && mem_rvalid_i) begin
        err_q <= mem_err_i;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    alu_valid_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = ready_q;
        if (accept) state_d = misaligned ? S_RESP : S_RD_REQ;
      end
      S_RD_REQ: begin
        mem_req_o = 1'b1;
        if (flush_i) state_d = mem_gnt_i ? S_DRAIN : S_IDLE;
        else if (mem_gnt_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (flush_i) state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
        else if (mem_rvalid_i) state_d = mem_err_i ? S_RESP : S_EXEC;
      end
      S_EXEC: begin
        alu_valid_o = 1'b1;
        state_d = flush_i ? S_IDLE : S_EXEC_WAIT;
      end
      S_EXEC_WAIT: begin
        if (flush_i) state_d = S_IDLE;
        else if (alu_ready_i) state_d = S_WR_REQ;
      end
      // from here on the write is committed and flush is ignored
      S_WR_REQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_gnt_i) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem_rvalid_i) state_d = S_RESP;
      end
      S_DRAIN: begin
        if (mem_rvalid_i) state_d = S_IDLE;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = result_q;
  assign alu_op_a_o  = old_q;
  assign alu_op_b_o  = data_q;
  assign alu_funct_o = funct_q;
  assign resp_data_o = old_q;
  assign resp_rd_o   = rd_q;
  assign resp_err_o  = err_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// tb/tb_amo_sequencer.sv - directed bench for amo_sequencer
// Bench-side memory and amo_unit models respond to the DUT; each step checks against hand-computed values.
module tb_amo_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic [63:0] req_data_i;
  logic [2:0]  req_funct_i;
  logic [4:0]  req_rd_i;
  logic        flush_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        mem_err_i;
  logic        alu_valid_o;
  logic [63:0] alu_op_a_o;
  logic [63:0] alu_op_b_o;
  logic [2:0]  alu_funct_o;
  logic        alu_ready_i;
  logic [63:0] alu_result_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] resp_data_o;
  logic [4:0]  resp_rd_o;
  logic        resp_err_o;

  amo_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .req_funct_i  (req_funct_i),
    .req_rd_i     (req_rd_i),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .alu_valid_o  (alu_valid_o),
    .alu_op_a_o   (alu_op_a_o),
    .alu_op_b_o   (alu_op_b_o),
    .alu_funct_o  (alu_funct_o),
    .alu_ready_i  (alu_ready_i),
    .alu_result_i (alu_result_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_rd_o    (resp_rd_o),
    .resp_err_o   (resp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mem [logic [63:0]];
  int          gnt_delay = 0;
  int          gnt_wait = 0;
  int          rv_delay = 1;
  int          rv_cnt = 0;
  logic [63:0] pend_data = 64'd0;
  logic        pend_err = 1'b0;
  logic        rd_err_en = 1'b0;
  logic        wr_err_en = 1'b0;
  logic        alu_pend = 1'b0;
  logic [63:0] alu_res = 64'd0;
  int          n_rd = 0, n_wr = 0, n_alu = 0, n_req_cyc = 0, n_unstable = 0, n_drop = 0;
  logic [63:0] last_waddr = 64'd0;

  logic        hold_act = 1'b0, hold_we = 1'b0, hold_flush = 1'b0;
  logic [63:0] hold_addr = 64'd0, hold_wdata = 64'd0;

  logic        req_s, we_s, alu_v_s, resp_v_s, resp_e_s, rdy_s, acc_rdy;
  logic [63:0] addr_s, wdata_s, a_s, b_s, resp_d_s;
  logic [2:0]  f_s;
  logic [4:0]  resp_rd_s;
  logic        rdy_hist [0:63];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample DUT outputs mid-cycle, drive model responses, then update models after the edge.
  task automatic tick();
    @(negedge clk);
    req_s = mem_req_o; we_s = mem_we_o; addr_s = mem_addr_o; wdata_s = mem_wdata_o;
    alu_v_s = alu_valid_o; a_s = alu_op_a_o; b_s = alu_op_b_o; f_s = alu_funct_o;
    resp_v_s = resp_valid_o; resp_d_s = resp_data_o; resp_rd_s = resp_rd_o; resp_e_s = resp_err_o;
    rdy_s = req_ready_o;
    mem_gnt_i    = req_s && (gnt_wait >= gnt_delay);
    mem_rvalid_i = (rv_cnt == 1);
    mem_rdata_i  = mem_rvalid_i ? pend_data : 64'd0;
    mem_err_i    = mem_rvalid_i && pend_err;
    alu_ready_i  = alu_pend;
    alu_result_i = alu_pend ? alu_res : 64'd0;
    if (req_s) n_req_cyc++;
    if (hold_act && req_s && (addr_s !== hold_addr || we_s !== hold_we || (we_s && wdata_s !== hold_wdata)))
      n_unstable++;
    if (hold_act && !req_s && !hold_flush) n_drop++;
    @(posedge clk);
    #1;
    hold_act = req_s && !mem_gnt_i; hold_addr = addr_s; hold_we = we_s; hold_wdata = wdata_s;
    hold_flush = flush_i;
    if (rv_cnt > 0) rv_cnt--;
    if (req_s && mem_gnt_i) begin
      gnt_wait = 0;
      rv_cnt = rv_delay;
      if (we_s) begin
        mem[addr_s] = wdata_s; n_wr++; last_waddr = addr_s;
        pend_data = 64'd0; pend_err = wr_err_en;
      end else begin
        n_rd++;
        pend_data = mem.exists(addr_s) ? mem[addr_s] : 64'd0;
        pend_err = rd_err_en;
      end
    end else if (req_s) begin
      gnt_wait++;
    end
    alu_pend = alu_v_s;
    if (alu_v_s) begin
      n_alu++;
      alu_res = (f_s == 3'd0) ? a_s + b_s : b_s;
    end
  endtask

  // C0 is the accept cycle; lat is the first cycle with resp_valid_o, 0 if none within max_cyc.
  task automatic run_op(input logic [63:0] a, input logic [63:0] d, input logic [2:0] f, input logic [4:0] rd,
                        input int flush_at, input int max_cyc, output int lat);
    req_addr_i = a; req_data_i = d; req_funct_i = f; req_rd_i = rd; req_valid_i = 1'b1;
    tick();
    acc_rdy = rdy_s;
    req_valid_i = 1'b0;
    lat = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      flush_i = (k == flush_at);
      tick();
      flush_i = 1'b0;
      rdy_hist[k] = rdy_s;
      if (resp_v_s) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat, rd0, wr0, alu0, rq0;

  initial begin
    rst_n = 1'b0; req_valid_i = 1'b0; req_addr_i = 64'd0; req_data_i = 64'd0; req_funct_i = 3'd0;
    req_rd_i = 5'd0; flush_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'd0;
    mem_err_i = 1'b0; alu_ready_i = 1'b0; alu_result_i = 64'd0; resp_ready_i = 1'b1;

    #2;
    check("rst_req_ready", 64'(req_ready_o), 64'd0);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("rst_alu_valid", 64'(alu_valid_o), 64'd0);
    check("rst_resp_data", resp_data_o, 64'd0);
    #10 rst_n = 1'b1;
    #1 check("ready_before_edge", 64'(req_ready_o), 64'd0);
    @(posedge clk); #1;
    check("ready_after_edge", 64'(req_ready_o), 64'd1);

    // AMOADD best case
    mem[64'h1000] = 64'd5;
    rd0 = n_rd; wr0 = n_wr;
    run_op(64'h1000, 64'd3, 3'd0, 5'd7, 0, 20, lat);
    check("add_accept_ready", 64'(acc_rdy), 64'd1);
    check("add_ready_low_c1", 64'(rdy_hist[1]), 64'd0);
    check("add_latency", 64'(lat), 64'd7);
    check("add_resp_data", resp_d_s, 64'd5);
    check("add_resp_rd", 64'(resp_rd_s), 64'd7);
    check("add_resp_err", 64'(resp_e_s), 64'd0);
    check("add_reads", 64'(n_rd - rd0), 64'd1);
    check("add_writes", 64'(n_wr - wr0), 64'd1);
    check("add_waddr", last_waddr, 64'h1000);
    check("add_mem", mem[64'h1000], 64'd8);
    tick();
    check("add_ready_after_hs", 64'(rdy_s), 64'd1);

    // AMOSWAP with 3-cycle grant delay on both phases
    mem[64'h2008] = 64'hAAAA;
    gnt_delay = 3;
    run_op(64'h2008, 64'h5555, 3'd1, 5'd3, 0, 40, lat);
    gnt_delay = 0;
    check("swap_latency", 64'(lat), 64'd13);
    check("swap_resp_data", resp_d_s, 64'hAAAA);
    check("swap_mem", mem[64'h2008], 64'h5555);
    check("swap_stable", 64'(n_unstable), 64'd0);
    check("swap_no_drop", 64'(n_drop), 64'd0);

    // misaligned
    rq0 = n_req_cyc;
    run_op(64'h1004, 64'd1, 3'd0, 5'd2, 0, 10, lat);
    check("mis_latency", 64'(lat), 64'd1);
    check("mis_err", 64'(resp_e_s), 64'd1);
    check("mis_data", resp_d_s, 64'd0);
    check("mis_rd", 64'(resp_rd_s), 64'd2);
    check("mis_no_mem", 64'(n_req_cyc - rq0), 64'd0);

    // read fault
    mem[64'h3000] = 64'h1234;
    rd_err_en = 1'b1; wr0 = n_wr; alu0 = n_alu;
    run_op(64'h3000, 64'd1, 3'd0, 5'd4, 0, 20, lat);
    rd_err_en = 1'b0;
    check("rderr_latency", 64'(lat), 64'd3);
    check("rderr_err", 64'(resp_e_s), 64'd1);
    check("rderr_no_write", 64'(n_wr - wr0), 64'd0);
    check("rderr_no_alu", 64'(n_alu - alu0), 64'd0);

    // write-ack fault
    mem[64'h3008] = 64'h77;
    wr_err_en = 1'b1; wr0 = n_wr;
    run_op(64'h3008, 64'd1, 3'd0, 5'd5, 0, 20, lat);
    wr_err_en = 1'b0;
    check("wrerr_latency", 64'(lat), 64'd7);
    check("wrerr_err", 64'(resp_e_s), 64'd1);
    check("wrerr_data", resp_d_s, 64'h77);
    check("wrerr_writes", 64'(n_wr - wr0), 64'd1);

    // flush in RD_WAIT with rvalid arriving later
    rv_delay = 3; rd0 = n_rd; wr0 = n_wr; alu0 = n_alu;
    run_op(64'h1000, 64'd1, 3'd0, 5'd6, 2, 8, lat);
    rv_delay = 1;
    check("fl_rd_no_resp", 64'(lat), 64'd0);
    check("fl_rd_reads", 64'(n_rd - rd0), 64'd1);
    check("fl_rd_no_write", 64'(n_wr - wr0), 64'd0);
    check("fl_rd_no_alu", 64'(n_alu - alu0), 64'd0);
    check("fl_rd_drain_busy", 64'(rdy_hist[4]), 64'd0);
    check("fl_rd_ready_after", 64'(rdy_hist[5]), 64'd1);
    check("fl_rd_mem", mem[64'h1000], 64'd8);

    // flush in WR_WAIT is ignored
    run_op(64'h1000, 64'd2, 3'd0, 5'd9, 6, 20, lat);
    check("fl_wr_latency", 64'(lat), 64'd7);
    check("fl_wr_data", resp_d_s, 64'd8);
    check("fl_wr_rd", 64'(resp_rd_s), 64'd9);
    check("fl_wr_mem", mem[64'h1000], 64'd10);

    // response back-pressure for 4 cycles
    resp_ready_i = 1'b0; rd0 = n_rd; rq0 = n_req_cyc;
    run_op(64'h2008, 64'h11, 3'd0, 5'd12, 0, 20, lat);
    check("bp_latency", 64'(lat), 64'd7);
    req_addr_i = 64'h1000; req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid_held", 64'(resp_v_s), 64'd1);
      check("bp_data_held", resp_d_s, 64'h5555);
      check("bp_ready_low", 64'(rdy_s), 64'd0);
    end
    req_valid_i = 1'b0; resp_ready_i = 1'b1;
    tick();
    check("bp_rd_held", 64'(resp_rd_s), 64'd12);
    tick();
    check("bp_ready_after", 64'(rdy_s), 64'd1);
    check("bp_resp_gone", 64'(resp_v_s), 64'd0);
    check("bp_one_read", 64'(n_rd - rd0), 64'd1);
    check("bp_mem", mem[64'h2008], 64'h5566);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
